mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 26 ++
 rtl/mix_column_word.sv | 35 +++
 rtl/mix_columns_seq.sv | 103 ++++++++++
 tb/tb_mix_columns_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------+
// | aes_pkg : shared AES constants, GF(2^8) xtime, datapath typedefs     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column_word.sv
// +----------------------------------------------------------------------+
// | mix_column_word : one combinational AES MixColumns column transform  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mix_column_word
  import aes_pkg::*;
(
  input  aes_word_t col_in,
  output aes_word_t col_out
);

  logic [7:0] w_a, w_b, w_c, w_d;
  logic [7:0] w_a2, w_b2, w_c2, w_d2;

  assign w_a = col_in[31:24];
  assign w_b = col_in[23:16];
  assign w_c = col_in[15:8];
  assign w_d = col_in[7:0];

  assign w_a2 = xtime(w_a);
  assign w_b2 = xtime(w_b);
  assign w_c2 = xtime(w_c);
  assign w_d2 = xtime(w_d);

  // 3x is folded in as 2x ^ x so each byte is one xtime plus an XOR tree
  assign col_out = {w_a2 ^ w_b2 ^ w_b ^ w_c ^ w_d,
                    w_a ^ w_b2 ^ w_c2 ^ w_c ^ w_d,
                    w_a ^ w_b ^ w_c2 ^ w_d2 ^ w_d,
                    w_a2 ^ w_a ^ w_b ^ w_c ^ w_d2};

endmodule

`default_nettype wire

// File: rtl/mix_columns_seq.sv
// +----------------------------------------------------------------------+
// | mix_columns_seq : column-serial AES MixColumns with valid/ready      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state
);

  localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] c_last_cnt = 2'(4 - COLS_PER_CYCLE);

  mc_fsm_t    r_fsm;
  mc_fsm_t    w_fsm_next;
  aes_state_t r_state;
  aes_state_t w_mixed;
  logic       r_last;
  logic [1:0] r_col_cnt;
  logic       w_accept;

  logic [1:0] w_idx     [COLS_PER_CYCLE];
  aes_word_t  w_col_in  [COLS_PER_CYCLE];
  aes_word_t  w_col_out [COLS_PER_CYCLE];

  // Column c sits at bits [127-32c -: 32], i.e. base offset 32*(3-c) = {~c,5'b0}
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign w_idx[g]    = r_col_cnt + 2'(g);
    assign w_col_in[g] = r_state[{~w_idx[g], 5'b0} +: 32];

    mix_column_word u_mix (
      .col_in  (w_col_in[g]),
      .col_out (w_col_out[g])
    );
  end

  always_comb begin
    w_mixed = r_state;
    if (!r_last) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        w_mixed[{~w_idx[g], 5'b0} +: 32] = w_col_out[g];
      end
    end
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    unique case (r_fsm)
      IDLE:    if (in_valid) w_fsm_next = BUSY;
      BUSY:    if (r_col_cnt == c_last_cnt) w_fsm_next = DONE;
      DONE:    if (out_ready) w_fsm_next = in_valid ? BUSY : IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
    out_valid = (r_fsm == DONE);
  end

  // A final-round state still walks all columns so latency stays constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_last    <= 1'b0;
      r_col_cnt <= 2'd0;
    end else if (w_accept) begin
      r_state   <= in_state;
      r_last    <= in_last;
      r_col_cnt <= 2'd0;
    end else if (r_fsm == BUSY) begin
      r_state   <= w_mixed;
      r_col_cnt <= r_col_cnt + c_step;
    end
  end

  assign out_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// +----------------------------------------------------------------------+
// | tb_mix_columns_seq : self-checking bench for mix_columns_seq          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mix_columns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [127:0] in_state, out_state;

  logic         iv_x, ir2, ir4, ov2, ov4;
  logic         x_last  = 1'b0;
  logic         x_ready = 1'b1;
  logic [127:0] x_state, os2, os4;

  logic [31:0]  w_in, w_out;

  int checks = 0;
  int errors = 0;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir2),
    .in_state(x_state), .in_last(x_last), .out_valid(ov2),
    .out_ready(x_ready), .out_state(os2));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir4),
    .in_state(x_state), .in_last(x_last), .out_valid(ov4),
    .out_ready(x_ready), .out_state(os4));

  mix_column_word u_word (.col_in(w_in), .col_out(w_out));

  typedef struct {
    logic [127:0] st;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] col;
    logic [31:0] exp;
  } wvec_t;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COMBO_IN  = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
  localparam logic [127:0] COMBO_OUT = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic lst);
    logic [7:0]   col  [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = s;
    if (!lst) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 4; k++) col[k] = s[127 - 32*c - 8*k -: 8];
        for (int rr = 0; rr < 4; rr++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[k], coef[(k - rr + 4) % 4]);
          r[127 - 32*c - 8*rr -: 8] = acc;
        end
      end
    end
    return r;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vector(input logic [127:0] st, input logic lst,
                            input logic [127:0] exp, input int idx);
    int lat;
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    in_state  = st;
    in_last   = lst;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk($sformatf("vec%0d_state", idx), out_state, exp);
    chk($sformatf("vec%0d_latency", idx), 128'(lat), 128'd4);
  endtask

  vec_t         vecs  [5];
  wvec_t        wvecs [4];
  logic [127:0] exp_q [$];

  initial begin
    int lat, lat2, lat4, sent, recvd;
    logic took;
    logic [127:0] st2, st4, expv;

    vecs[0] = '{FIPS_IN, 1'b0, FIPS_OUT};
    vecs[1] = '{COMBO_IN, 1'b0, COMBO_OUT};
    vecs[2] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff};
    vecs[3] = '{128'h0, 1'b0, 128'h0};
    vecs[4] = '{FIPS_IN, 1'b1, FIPS_IN};

    wvecs[0] = '{32'hdb135345, 32'h8e4da1bc};
    wvecs[1] = '{32'hf20a225c, 32'h9fdc589d};
    wvecs[2] = '{32'hc6c6c6c6, 32'hc6c6c6c6};
    wvecs[3] = '{32'hd4d4d4d5, 32'hd5d5d7d6};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_state = '0; iv_x = 1'b0; x_state = FIPS_IN; w_in = '0;
    #3;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      w_in = wvecs[i].col;
      #1;
      chk($sformatf("word%0d", i), 128'(w_out), 128'(wvecs[i].exp));
    end

    // FIPS vector latency for the wider lane configurations
    @(negedge clk);
    iv_x = 1'b1;
    @(negedge clk);
    iv_x = 1'b0;
    lat2 = -1; lat4 = -1; st2 = '0; st4 = '0;
    for (int k = 0; k < 8; k++) begin
      if (ov2 && lat2 < 0) begin lat2 = k; st2 = os2; end
      if (ov4 && lat4 < 0) begin lat4 = k; st4 = os4; end
      @(negedge clk);
    end
    chk("cpc2_latency", 128'(lat2), 128'd2);
    chk("cpc2_state", st2, FIPS_OUT);
    chk("cpc4_latency", 128'(lat4), 128'd1);
    chk("cpc4_state", st4, FIPS_OUT);

    for (int i = 0; i < 5; i++) run_vector(vecs[i].st, vecs[i].last, vecs[i].exp, i);

    // Backpressure, then back-to-back acceptance in the release cycle
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; in_state = FIPS_IN; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_state = COMBO_IN;
    wait_valid(lat);
    chk("bp_first_latency", 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_state", out_state, FIPS_OUT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_busy_out_valid", 128'(out_valid), 128'd0);
    wait_valid(lat);
    chk("bp_second_latency", 128'(lat), 128'd4);
    chk("bp_second_state", out_state, COMBO_OUT);

    // Asynchronous reset with col_cnt at 2
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1; in_state = FIPS_IN; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_state", out_state, 128'h0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vector(COMBO_IN, 1'b0, COMBO_OUT, 10);

    // Random stream against the reference model
    @(negedge clk);
    in_valid = 1'b0;
    sent = 0; recvd = 0; took = 1'b0;
    for (int cyc = 0; cyc < 20000 && recvd < 1000; cyc++) begin
      @(negedge clk);
      if (!in_valid || took) begin
        took = 1'b0;
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_state = {$urandom, $urandom, $urandom, $urandom};
          in_last  = ($urandom_range(0, 7) == 0);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #4;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mix(in_state, in_last));
        sent++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_output", out_state, 128'hx);
        end else begin
          expv = exp_q.pop_front();
          chk($sformatf("rand_out%0d", recvd), out_state, expv);
        end
        recvd++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("rand_received", 128'(recvd), 128'd1000);
    chk("rand_leftover", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
